// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic voice slot allocator with retrigger, steal and kill gap
module voice_allocator #(
  parameter int NVOICES     = 4,
  parameter int KILL_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ev_valid,
  output logic                    ev_ready,
  input  logic                    ev_on,
  input  logic [6:0]              ev_note,
  input  logic [20:0]             ev_pitch,
  input  logic                    panic,
  output logic [NVOICES-1:0]      gate,
  output logic [21*NVOICES-1:0]   pitch_bus,
  output logic                    busy
);

  localparam int IW = $clog2(NVOICES);

  typedef enum logic [1:0] {IDLE, DECIDE, KILL, START} state_t;

  state_t              state, state_nxt;
  logic [6:0]          note_q  [NVOICES];
  logic [20:0]         pitch_q [NVOICES];
  logic [7:0]          age_q   [NVOICES];
  logic [NVOICES-1:0]  gate_q;
  logic                lat_on;
  logic [6:0]          lat_note;
  logic [20:0]         lat_pitch;
  logic [IW-1:0]       tgt;
  logic [7:0]          kill_cnt;
  logic                rdy_en;

  logic                hit, free_any, accept;
  logic [IW-1:0]       hit_idx, free_idx, old_idx, kill_idx, wr_idx;
  logic [7:0]          old_age;
  logic                kill_en, wr_en, off_en;

  assign ev_ready = rdy_en && (state == IDLE) && !panic;
  assign accept   = ev_valid && ev_ready;
  assign busy     = (state != IDLE);
  assign gate     = gate_q;

  for (genvar g = 0; g < NVOICES; g++) begin : g_bus
    assign pitch_bus[21*g +: 21] = pitch_q[g];
  end

  // Target candidates; strict '>' on age keeps the lowest index on ties.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age_q[0];
    for (int i = 0; i < NVOICES; i++) begin
      if (!hit && gate_q[i] && note_q[i] == lat_note) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (!free_any && !gate_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    kill_en   = 1'b0;
    kill_idx  = hit ? hit_idx : old_idx;
    wr_en     = 1'b0;
    wr_idx    = free_idx;
    off_en    = 1'b0;
    case (state)
      IDLE:   if (accept) state_nxt = DECIDE;
      DECIDE: begin
        if (!lat_on) begin
          off_en    = 1'b1;
          state_nxt = IDLE;
        end else if (!hit && free_any) begin
          wr_en     = 1'b1;
          state_nxt = IDLE;
        end else begin
          kill_en   = 1'b1;
          state_nxt = (KILL_CYCLES == 1) ? START : KILL;
        end
      end
      // The START clock is the last gap clock, so the gate stays low KILL_CYCLES clocks.
      KILL:   if (kill_cnt <= 8'd2) state_nxt = START;
      START: begin
        wr_en     = 1'b1;
        wr_idx    = tgt;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (panic) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      lat_on    <= 1'b0;
      lat_note  <= '0;
      lat_pitch <= '0;
      tgt       <= '0;
      kill_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (accept) begin
        lat_on    <= ev_on;
        lat_note  <= ev_note;
        lat_pitch <= ev_pitch;
      end
      if (kill_en) tgt <= kill_idx;
      if (panic)                kill_cnt <= '0;
      else if (kill_en)         kill_cnt <= 8'(KILL_CYCLES);
      else if (kill_cnt != '0 && (state == KILL || state == START))
                                kill_cnt <= kill_cnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_q <= '0;
      for (int i = 0; i < NVOICES; i++) begin
        note_q[i]  <= '0;
        pitch_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else if (panic) begin
      gate_q <= '0;
      for (int i = 0; i < NVOICES; i++) age_q[i] <= '0;
    end else begin
      if (kill_en) gate_q[kill_idx] <= 1'b0;
      if (off_en) begin
        for (int i = 0; i < NVOICES; i++)
          if (gate_q[i] && note_q[i] == lat_note) gate_q[i] <= 1'b0;
      end
      if (wr_en) begin
        note_q[wr_idx]  <= lat_note;
        pitch_q[wr_idx] <= lat_pitch;
        gate_q[wr_idx]  <= 1'b1;
        for (int i = 0; i < NVOICES; i++)
          age_q[i] <= (IW'(i) == wr_idx) ? 8'd0 :
                      (age_q[i] == 8'hFF) ? 8'hFF : age_q[i] + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb/tb_voice_allocator.sv - directed self-checking bench for voice_allocator
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_on;
  logic [6:0]  ev_note;
  logic [20:0] ev_pitch;
  logic        panic;
  logic [3:0]  gate;
  logic [83:0] pitch_bus;
  logic        busy;

  int checks = 0;
  int errors = 0;

  voice_allocator #(.NVOICES(4), .KILL_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_pitch(ev_pitch), .panic(panic),
    .gate(gate), .pitch_bus(pitch_bus), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [20:0] pslot(input int i);
    return pitch_bus[21*i +: 21];
  endfunction

  // Waits for ev_ready, then holds the event for exactly one accepting edge.
  task automatic send(input logic on, input logic [6:0] note, input logic [20:0] p);
    int n = 0;
    while (!ev_ready && n < 20) begin
      tick();
      n++;
    end
    if (!ev_ready) check("ready_timeout", 0, 1);
    ev_valid = 1'b1;
    ev_on    = on;
    ev_note  = note;
    ev_pitch = p;
    tick();
    ev_valid = 1'b0;
  endtask

  // Called right after the DECIDE edge: counts clocks slot idx stays low.
  task automatic low_len(input int idx, output int cnt);
    cnt = 0;
    while (gate[idx] == 1'b0 && cnt < 40) begin
      cnt++;
      tick();
    end
  endtask

  int cnt;
  int acc;
  logic [6:0]  bb_note  [3];
  logic [20:0] bb_pitch [3];

  initial begin
    rst_n = 1'b0; ev_valid = 1'b0; ev_on = 1'b0; ev_note = '0; ev_pitch = '0; panic = 1'b0;
    #12;
    check("rst_gate", gate, 4'b0000);
    check("rst_pitch", pitch_bus, 84'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", ev_ready, 1'b0);
    #10 rst_n = 1'b1;
    #1 check("ready_before_edge", ev_ready, 1'b0);
    tick();
    check("ready_after_rst", ev_ready, 1'b1);

    // Single note-on into a free slot
    send(1'b1, 7'd60, 21'h01000);
    check("on60_busy", busy, 1'b1);
    check("on60_gate_early", gate, 4'b0000);
    tick();
    check("on60_gate", gate, 4'b0001);
    check("on60_pitch", pslot(0), 21'h01000);
    check("on60_busy_done", busy, 1'b0);

    // Fill remaining slots; ages become 3,2,1,0
    send(1'b1, 7'd62, 21'h02000); tick();
    send(1'b1, 7'd64, 21'h03000); tick();
    send(1'b1, 7'd65, 21'h04000); tick();
    check("fill_gate", gate, 4'b1111);
    check("fill_pitch3", pslot(3), 21'h04000);

    // Steal the oldest slot (0)
    send(1'b1, 7'd67, 21'h05000); tick();
    check("steal_gate_drop", gate, 4'b1110);
    low_len(0, cnt);
    check("steal_low_len", cnt, 4);
    check("steal_gate", gate, 4'b1111);
    check("steal_pitch0", pslot(0), 21'h05000);
    check("steal_others", pitch_bus[83:21], {21'h04000, 21'h03000, 21'h02000});

    // Retrigger the held note 67 on slot 0 with a new pitch
    send(1'b1, 7'd67, 21'h05500); tick();
    check("retrig_gate_drop", gate, 4'b1110);
    low_len(0, cnt);
    check("retrig_low_len", cnt, 4);
    check("retrig_gate", gate, 4'b1111);
    check("retrig_pitch0", pslot(0), 21'h05500);

    // Note-off of a held note, then of a note not held
    send(1'b0, 7'd62, 21'h1FFFFF); tick();
    check("off62_gate", gate, 4'b1101);
    check("off62_pitch", pslot(1), 21'h02000);
    check("off62_ready", ev_ready, 1'b1);
    send(1'b0, 7'd70, 21'h0);
    check("off70_ready_low", ev_ready, 1'b0);
    tick();
    check("off70_gate", gate, 4'b1101);
    check("off70_ready", ev_ready, 1'b1);

    // Free slot 1 reused; ages now s0=1 s1=0 s2=4 s3=3
    send(1'b1, 7'd70, 21'h07000); tick();
    check("on70_gate", gate, 4'b1111);
    check("on70_pitch", pslot(1), 21'h07000);

    // Panic during the kill gap of a steal of slot 2
    send(1'b1, 7'd72, 21'h08000); tick();
    check("steal2_gate_drop", gate, 4'b1011);
    tick();
    panic = 1'b1;
    tick();
    check("panic_gate", gate, 4'b0000);
    check("panic_busy", busy, 1'b0);
    check("panic_ready", ev_ready, 1'b0);
    panic = 1'b0;
    #1 check("panic_ready_drop", ev_ready, 1'b1);
    tick(); tick(); tick(); tick(); tick();
    check("panic_no_restart", gate, 4'b0000);
    check("panic_pitch_kept", pslot(2), 21'h03000);

    // Back-to-back events with ev_valid held high
    bb_note[0] = 7'd40; bb_pitch[0] = 21'h0A000;
    bb_note[1] = 7'd41; bb_pitch[1] = 21'h0B000;
    bb_note[2] = 7'd42; bb_pitch[2] = 21'h0C000;
    acc = 0;
    cnt = 0;
    ev_valid = 1'b1;
    ev_on    = 1'b1;
    while (acc < 3 && cnt < 30) begin
      ev_note  = bb_note[acc];
      ev_pitch = bb_pitch[acc];
      #1;
      if (ev_ready) acc++;
      tick();
      cnt++;
    end
    ev_valid = 1'b0;
    tick();
    check("bb_accepts", acc, 3);
    check("bb_cycles", cnt, 5);
    check("bb_gate", gate, 4'b0111);
    check("bb_pitches", pitch_bus[62:0], {21'h0C000, 21'h0B000, 21'h0A000});
    check("bb_slot3_kept", pslot(3), 21'h04000);

    // Reset in the middle of an event
    send(1'b1, 7'd50, 21'h0D000);
    rst_n = 1'b0;
    #1;
    check("midrst_gate", gate, 4'b0000);
    check("midrst_pitch", pitch_bus, 84'h0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_ready", ev_ready, 1'b0);
    #3 rst_n = 1'b1;
    tick();
    tick();
    check("postrst_ready", ev_ready, 1'b1);
    check("postrst_gate", gate, 4'b0000);
    check("postrst_pitch", pitch_bus, 84'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
